// File: rtl/williams_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : williams_video_pkg
// Purpose  : Shared types and constants for the Williams video blanking path.
//            Provides the sync-lock state encoding, the raw counter width and
//            a saturating increment helper used by the position counters.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package williams_video_pkg;

    localparam int               CNT_W   = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACK    = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    // Counters stick at CNT_MAX so a missing sync is visible as a full-scale
    // value instead of wrapping back into a plausible-looking position.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage : williams_video_pkg
`default_nettype wire

// File: rtl/williams_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : williams_sync_edge
// Purpose  : Registered rising-edge detector with a sample enable. The
//            history flop only advances when en_i is high, so an edge is
//            judged against the value seen at the previous enabled sample.
// Ports    : clk_i   in  clock
//            rst_i   in  asynchronous active-high reset (history cleared)
//            en_i    in  sample enable
//            d_i     in  level being watched
//            rise_o  out d_i high now, low at the previous enabled sample
// Revision : 1.0  initial release
// ============================================================================
module williams_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
        end else if (en_i) begin
            d_q <= d_i;
        end
    end

    assign rise_o = en_i & d_i & ~d_q;

endmodule : williams_sync_edge
`default_nettype wire

// File: rtl/williams_blank_gen.sv
`default_nettype none
// ============================================================================
// Module   : williams_blank_gen
// Purpose  : Derives pixel enable, horizontal/vertical blanking and a sync
//            lock flag from the raw hs/vs of the Williams SoC. The picture
//            is force-blanked until the frame length has repeated
//            LOCK_FRAMES times in a row.
// Macro    : WILLIAMS_BLANK_MEASURE_EN adds the line_len / frame_lines
//            measurement outputs; without it they do not exist.
// Ports    : clk_sys     in  system clock
//            reset       in  asynchronous active-high reset
//            hs_in       in  horizontal sync, active high
//            vs_in       in  vertical sync, active high
//            ce_pix      out pixel enable (pixel counter LSB)
//            hblank      out horizontal blank (forced while unlocked)
//            vblank      out vertical blank (forced while unlocked)
//            locked      out sync geometry stable
//            line_len    out clk_sys cycles per line      (macro only)
//            frame_lines out lines per frame              (macro only)
// Revision : 1.0  initial release
// ============================================================================
module williams_blank_gen
    import williams_video_pkg::*;
#(
    parameter int H_START     = 336,
    parameter int H_END       = 40,
    parameter int V_START     = 246,
    parameter int V_END       = 6,
    parameter int LOCK_FRAMES = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic        ce_pix,
    output logic        hblank,
    output logic        vblank,
    output logic        locked
`ifdef WILLIAMS_BLANK_MEASURE_EN
    ,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines
`endif
);

    localparam logic [9:0]       c_h_start = 10'(H_START);
    localparam logic [9:0]       c_h_end   = 10'(H_END);
    localparam logic [CNT_W-1:0] c_v_start = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] c_v_end   = CNT_W'(V_END);
    localparam logic [3:0]       c_lock_n  = 4'(LOCK_FRAMES);

    // ------------------------------------------------------------------
    // Sync edges. vs is only sampled on hs rising edges, so a vertical
    // edge always coincides with the first clock of a line.
    // ------------------------------------------------------------------
    logic hs_rise;
    logic vs_rise;

    williams_sync_edge u_hs_edge (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .en_i   (1'b1),
        .d_i    (hs_in),
        .rise_o (hs_rise)
    );

    williams_sync_edge u_vs_edge (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .en_i   (hs_rise),
        .d_i    (vs_in),
        .rise_o (vs_rise)
    );

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic             hb_q, hb_d;
    logic             vb_q, vb_d;

    always_comb begin
        pcnt_d = hs_rise ? '0 : sat_inc(pcnt_q);

        lcnt_d = lcnt_q;
        if (hs_rise) begin
            lcnt_d = vs_rise ? '0 : sat_inc(lcnt_q);
        end

        // Horizontal compare uses the pixel index (two clocks per pixel).
        hb_d = hb_q;
        if (pcnt_q[10:1] == c_h_start) begin
            hb_d = 1'b1;
        end else if (pcnt_q[10:1] == c_h_end) begin
            hb_d = 1'b0;
        end

        vb_d = vb_q;
        if (lcnt_q == c_v_start) begin
            vb_d = 1'b1;
        end else if (lcnt_q == c_v_end) begin
            vb_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
            lcnt_q <= '0;
            hb_q   <= 1'b1;
            vb_q   <= 1'b1;
        end else begin
            pcnt_q <= pcnt_d;
            lcnt_q <= lcnt_d;
            hb_q   <= hb_d;
            vb_q   <= vb_d;
        end
    end

    // ------------------------------------------------------------------
    // Lock tracking. The frame length is the number of lines since the
    // previous vertical edge; the one counted on this edge is included.
    // ------------------------------------------------------------------
    lock_state_t      state_q;
    logic [3:0]       match_q;
    logic [CNT_W-1:0] ref_q;
    logic             locked_q;
    logic [CNT_W-1:0] frame_len;
    logic [3:0]       match_inc;
    logic             sync_lost;

    assign frame_len = sat_inc(lcnt_q);
    assign match_inc = match_q + 4'd1;
    assign sync_lost = (pcnt_q == CNT_MAX) || (lcnt_q == CNT_MAX);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            match_q  <= '0;
            ref_q    <= '0;
            locked_q <= 1'b0;
        end else if (sync_lost) begin
            // A saturated counter means hs or vs has gone missing; this
            // outranks a vertical edge arriving in the same cycle.
            state_q  <= UNLOCKED;
            locked_q <= 1'b0;
        end else if (vs_rise) begin
            case (state_q)
                UNLOCKED: begin
                    ref_q    <= frame_len;
                    match_q  <= '0;
                    state_q  <= TRACK;
                    locked_q <= 1'b0;
                end
                TRACK: begin
                    if (frame_len == ref_q) begin
                        match_q <= match_inc;
                        if (match_inc == c_lock_n) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end else begin
                        ref_q   <= frame_len;
                        match_q <= '0;
                    end
                end
                LOCKED: begin
                    if (frame_len != ref_q) begin
                        ref_q    <= frame_len;
                        match_q  <= '0;
                        state_q  <= TRACK;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= UNLOCKED;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ce_pix = pcnt_q[0];
    assign hblank = hb_q | ~locked_q;
    assign vblank = vb_q | ~locked_q;
    assign locked = locked_q;

`ifdef WILLIAMS_BLANK_MEASURE_EN
    logic [CNT_W-1:0] line_len_q;
    logic [CNT_W-1:0] frame_lines_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            line_len_q    <= '0;
            frame_lines_q <= '0;
        end else begin
            if (hs_rise) begin
                line_len_q <= sat_inc(pcnt_q);
            end
            if (vs_rise) begin
                frame_lines_q <= frame_len;
            end
        end
    end

    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
`endif

    // A window whose start equals its end never opens or closes.
    always @(posedge clk_sys) begin
        assert ((H_START != H_END) && (V_START != V_END))
            else $error("williams_blank_gen: blank start equals blank end");
    end

endmodule : williams_blank_gen
`default_nettype wire

// File: tb/tb_williams_blank_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_williams_blank_gen
// Purpose  : Scoreboard bench for williams_blank_gen. Stimulus drives a
//            reduced video geometry (64 clocks/line, 20 or 21 lines/frame)
//            and queues the expected outputs for specific clock cycles; an
//            independent monitor compares them when those cycles arrive.
// Revision : 1.0  initial release
// ============================================================================
module tb_williams_blank_gen;

    localparam int P     = 64;   // clocks per line
    localparam int HS_HI = 4;    // clocks of hs high per line
    localparam int N     = 20;   // lines per frame (nominal)
    localparam int NV    = 3;    // lines of vs high

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic        ce_pix, hblank, vblank, locked;
`ifdef WILLIAMS_BLANK_MEASURE_EN
    logic [10:0] line_len, frame_lines;
`endif

    williams_blank_gen #(
        .H_START     (24),
        .H_END       (4),
        .V_START     (16),
        .V_END       (2),
        .LOCK_FRAMES (4)
    ) dut (
        .clk_sys     (clk),
        .reset       (reset),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .ce_pix      (ce_pix),
        .hblank      (hblank),
        .vblank      (vblank),
        .locked      (locked)
`ifdef WILLIAMS_BLANK_MEASURE_EN
        ,
        .line_len    (line_len),
        .frame_lines (frame_lines)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // val/msk bit order: {locked, hblank, vblank, ce_pix}
    typedef struct {
        int          cyc;
        string       name;
        logic [3:0]  val;
        logic [3:0]  msk;
        bit          meas;
        logic [10:0] ll;
        logic [10:0] fl;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input int c, input string nm, input logic [3:0] v, input logic [3:0] m);
        exp_t x;
        x.cyc = c; x.name = nm; x.val = v; x.msk = m;
        x.meas = 1'b0; x.ll = '0; x.fl = '0;
        sbq.push_back(x);
    endtask

    task automatic push_meas(input int c, input string nm, input logic [10:0] ll, input logic [10:0] fl);
        exp_t x;
        x.cyc = c; x.name = nm; x.val = '0; x.msk = '0;
        x.meas = 1'b1; x.ll = ll; x.fl = fl;
        sbq.push_back(x);
    endtask

    // ---------------------------------------------------------------- monitor
    task automatic check_entry(input exp_t x);
        logic [3:0] got;
        total++;
        if (x.cyc != cyc) begin
            bad++;
            $display("FAIL %s: due at cycle %0d, checked at cycle %0d", x.name, x.cyc, cyc);
        end else if (x.meas) begin
`ifdef WILLIAMS_BLANK_MEASURE_EN
            if (line_len !== x.ll || frame_lines !== x.fl) begin
                bad++;
                $display("FAIL %s @%0d: line_len=%0d frame_lines=%0d, want %0d/%0d",
                         x.name, cyc, line_len, frame_lines, x.ll, x.fl);
            end
`else
            bad++;
            $display("FAIL %s: measurement outputs not present", x.name);
`endif
        end else begin
            got = {locked, hblank, vblank, ce_pix};
            if ((got & x.msk) !== (x.val & x.msk)) begin
                bad++;
                $display("FAIL %s @%0d: {locked,hblank,vblank,ce}=%b want %b (mask %b)",
                         x.name, cyc, got, x.val, x.msk);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                check_entry(sbq[i]);
                sbq.delete(i);
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    // Each line's first clock carries hs=1; e is the edge that samples it.
    task automatic line_begin(input bit vs, output int e);
        @(negedge clk);
        hs_in = 1'b1;
        vs_in = vs;
        e     = cyc + 1;
    endtask

    task automatic line_rest(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(negedge clk);
            hs_in = (i < HS_HI);
        end
    endtask

    task automatic send_frame(input int n, input bit lk, input bit timing, output int e_last);
        int e;
        e = 0;
        for (int l = 0; l < n; l++) begin
            line_begin(l < NV, e);
            if (l == 0) begin
                push(e, "lock_at_vs", {lk, 3'b000}, 4'b1000);
                if (!lk) push(e + 20, "forced_blank", 4'b0110, 4'b1110);
            end
            if (timing) begin
                if (l == 0) begin
                    push(e + 8,  "hb_hold", 4'b1110, 4'b1111);
                    push(e + 9,  "hb_fall", 4'b1011, 4'b1111);
                    push(e + 48, "hb_low",  4'b1010, 4'b1111);
                    push(e + 49, "hb_rise", 4'b1111, 4'b1111);
                end
                if (l == 2) begin
                    push(e,     "vb_hold", 4'b1110, 4'b1111);
                    push(e + 1, "vb_fall", 4'b1101, 4'b1111);
                end
                if (l == 16) begin
                    push(e,     "vb_low",  4'b1100, 4'b1111);
                    push(e + 1, "vb_rise", 4'b1111, 4'b1111);
                end
            end
            line_rest(1, P);
        end
        e_last = e;
    endtask

    task automatic partial_frame();
        int e;
        for (int l = 0; l < N - 1; l++) begin
            line_begin(1'b0, e);
            if (l == 0) push(e + 20, "unlocked_blank", 4'b0110, 4'b1110);
            line_rest(1, P);
        end
    endtask

    initial begin
        int el;
        int e;

        // Reset state
        repeat (3) @(negedge clk);
        push(cyc + 1, "reset_state", 4'b0110, 4'b1111);
`ifdef WILLIAMS_BLANK_MEASURE_EN
        push_meas(cyc + 1, "reset_meas", 11'd0, 11'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Lock acquisition: the first vs edge already sees a full frame
        partial_frame();
        send_frame(N, 1'b0, 1'b0, el);
`ifdef WILLIAMS_BLANK_MEASURE_EN
        push_meas(el + P, "meas_first_frame", 11'd64, 11'd20);
`endif
        for (int k = 2; k <= 4; k++) send_frame(N, 1'b0, 1'b0, el);
        send_frame(N, 1'b1, 1'b1, el);

        // One long frame drops lock, then four more long frames relock
        send_frame(N + 1, 1'b1, 1'b0, el);
        push(el + P - 1, "locked_before_drop", 4'b1000, 4'b1000);
`ifdef WILLIAMS_BLANK_MEASURE_EN
        push_meas(el + P, "meas_long_frame", 11'd64, 11'd21);
`endif
        for (int k = 0; k < 4; k++) send_frame(N + 1, 1'b0, 1'b0, el);
        send_frame(N + 1, 1'b1, 1'b0, el);

        // hs stops: pixel counter saturates and the watchdog unlocks
        push(el + 2047, "sat_still_locked", 4'b1001, 4'b1001);
        push(el + 2048, "watchdog_unlock",  4'b0111, 4'b1111);
        push(el + 2100, "held_unlocked",    4'b0111, 4'b1111);
        line_rest(P, P + 2100);
        vs_in = 1'b0;
        push(el + P + 2100,     "pcnt_restart", 4'b0110, 4'b1111);
        push(el + P + 2100 + 1, "ce_after_restart", 4'b0111, 4'b1111);
`ifdef WILLIAMS_BLANK_MEASURE_EN
        push_meas(el + P + 2100, "meas_line_sat", 11'd2047, 11'd21);
`endif
        // The resume edge is swallowed by the watchdog, so six vs edges
        for (int k = 0; k < 5; k++) send_frame(N + 1, 1'b0, 1'b0, el);

        // Reset in the middle of an active line while locked
        send_frame(5, 1'b1, 1'b0, el);
        line_begin(1'b0, e);
        push(e + 30, "pre_reset_active", 4'b1000, 4'b1111);
        push(e + 31, "reset_mid_line",   4'b0110, 4'b1111);
`ifdef WILLIAMS_BLANK_MEASURE_EN
        push_meas(e + 31, "meas_mid_reset", 11'd0, 11'd0);
`endif
        line_rest(1, 31);
        @(negedge clk);
        reset = 1'b1;
        hs_in = 1'b0;
        vs_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        partial_frame();
        for (int k = 0; k < 4; k++) send_frame(N, 1'b0, 1'b0, el);
        send_frame(N, 1'b1, 1'b1, el);

        repeat (4) @(negedge clk);
        if (sbq.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations never checked, want 0", sbq.size());
            total += sbq.size();
            bad   += sbq.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_williams_blank_gen
`default_nettype wire
